// File: rtl/spatial_seq_pkg.sv
// Shared types and sizing for the spatial encoder front-end sequencer.
`ifndef MAX_NUM_CHANNEL_WIDTH
`define MAX_NUM_CHANNEL_WIDTH 4
`endif

package spatial_seq_pkg;
    localparam int CH_W   = `MAX_NUM_CHANNEL_WIDTH;
    localparam int MAX_CH = 1 << CH_W;
    localparam int LVL_W  = 5;
    localparam int FEAT_W = MAX_CH * LVL_W;

    typedef enum logic [1:0] {IDLE, ISSUE, STREAM, WAIT_OUT} seq_state_e;

    function automatic logic [LVL_W-1:0] level_of(input logic [FEAT_W-1:0] feat,
                                                  input logic [CH_W-1:0]   ch);
        return feat[ch*LVL_W +: LVL_W];
    endfunction

    // Channel count carries one extra bit so MAX_CH itself is representable.
    function automatic logic [CH_W:0] sat_num_ch(input logic [CH_W-1:0] n);
        logic [CH_W:0] w;
        w = {1'b0, n};
        return (w > MAX_CH[CH_W:0]) ? MAX_CH[CH_W:0] : w;
    endfunction
endpackage

// File: rtl/spatial_seq_addr_gen.sv
// Feature register, channel index and IM/CIM read address generation.
module spatial_seq_addr_gen
    import spatial_seq_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [FEAT_W-1:0]  feat_in,
    input  seq_state_e         state,
    input  logic               din_ready,
    input  logic [CH_W:0]      num_ch,
    output logic [CH_W-1:0]    idx,
    output logic               advance,
    output logic               last,
    output logic               im_rd_en,
    output logic [CH_W-1:0]    im_addr,
    output logic               cim_rd_en,
    output logic [LVL_W-1:0]   cim_addr
);
    logic [FEAT_W-1:0] feat;
    logic              stall;
    logic              rd;
    logic [CH_W-1:0]   rd_ch;

    always_comb begin
        // Channel 0 is the only handshaken beat; while it waits, re-read it so ROM data stays valid.
        stall   = (state == STREAM) && (idx == '0) && !din_ready;
        advance = (state == STREAM) && !stall;
        last    = ({1'b0, idx} + 1'b1) >= num_ch;
        rd      = 1'b0;
        rd_ch   = '0;
        case (state)
            ISSUE: begin
                rd    = 1'b1;
                rd_ch = '0;
            end
            STREAM: begin
                if (stall) begin
                    rd    = 1'b1;
                    rd_ch = idx;
                end else if (!last) begin
                    rd    = 1'b1;
                    rd_ch = idx + 1'b1;
                end
            end
            default: ;
        endcase
        im_rd_en  = rd;
        cim_rd_en = rd;
        im_addr   = rd_ch;
        cim_addr  = rd ? level_of(feat, rd_ch) : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            feat <= '0;
            idx  <= '0;
        end else begin
            if (load)
                feat <= feat_in;
            if (state != STREAM)
                idx <= '0;
            else if (advance && !last)
                idx <= idx + 1'b1;
        end
    end
endmodule

// File: rtl/spatial_channel_sequencer.sv
// Walks channels of one sample through IM/CIM ROM reads and issues one encoder job.
module spatial_channel_sequencer
    import spatial_seq_pkg::*;
(
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               sample_valid,
    output logic                               sample_ready,
    input  logic [MAX_CH*LVL_W-1:0]            sample_feat,
    input  logic [`MAX_NUM_CHANNEL_WIDTH-1:0]  cfg_num_channel,
    output logic                               im_rd_en,
    output logic [`MAX_NUM_CHANNEL_WIDTH-1:0]  im_addr,
    output logic                               cim_rd_en,
    output logic [LVL_W-1:0]                   cim_addr,
    output logic                               enc_din_valid,
    input  logic                               enc_din_ready,
    output logic [`MAX_NUM_CHANNEL_WIDTH-1:0]  enc_num_channel,
    input  logic                               enc_hvout_fire,
    output logic                               busy,
    output logic                               err_zero_ch,
    output logic [15:0]                        sample_count
);
    seq_state_e      state;
    logic [CH_W:0]   num_ch;
    logic [CH_W-1:0] idx;
    logic            advance;
    logic            last;
    logic            sample_fire;

    assign sample_ready    = (state == IDLE);
    assign busy            = (state != IDLE);
    assign sample_fire     = sample_valid && sample_ready;
    assign enc_din_valid   = (state == STREAM) && (idx == '0);
    assign enc_num_channel = num_ch[CH_W-1:0];

    spatial_seq_addr_gen u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (sample_fire),
        .feat_in   (sample_feat),
        .state     (state),
        .din_ready (enc_din_ready),
        .num_ch    (num_ch),
        .idx       (idx),
        .advance   (advance),
        .last      (last),
        .im_rd_en  (im_rd_en),
        .im_addr   (im_addr),
        .cim_rd_en (cim_rd_en),
        .cim_addr  (cim_addr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            num_ch       <= '0;
            err_zero_ch  <= 1'b0;
            sample_count <= '0;
        end else begin
            err_zero_ch <= 1'b0;
            case (state)
                IDLE: begin
                    if (sample_fire) begin
                        num_ch <= sat_num_ch(cfg_num_channel);
                        if (cfg_num_channel == '0)
                            err_zero_ch <= 1'b1;
                        else
                            state <= ISSUE;
                    end
                end
                ISSUE:  state <= STREAM;
                STREAM: if (advance && last) state <= WAIT_OUT;
                WAIT_OUT: begin
                    // The encoder output leaving is the only completion event we count.
                    if (enc_hvout_fire) begin
                        sample_count <= sample_count + 16'd1;
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
